// File: rtl/pcs_pkg.sv
// Shared PCS definitions: sync header values, block-lock FSM states and lock limits.
package pcs_pkg;

    localparam int HEAD_W = 2;

    localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b01;
    localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b10;

    localparam int SH_CNT_MAX_40G     = 1024;
    localparam int SH_INVALID_MAX_40G = 65;
    localparam int SH_CNT_MAX_10G     = 64;
    localparam int SH_INVALID_MAX_10G = 16;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    function automatic logic sync_valid(input logic [HEAD_W-1:0] head);
        return (head == SYNC_DATA) || (head == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/gearbox_rx.sv
// 64:66 receive gearbox: packs PMA words into a bit buffer, emits 66-bit blocks and executes bit slips.
module gearbox_rx #(
    parameter int DATA_W = 64,
    parameter int HEAD_W = 2
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     slip_i,
    output logic                     slip_ack,
    output logic                     valid_o,
    output logic [DATA_W+HEAD_W-1:0] block_o,
    output logic                     slip_o
);

    localparam int BLK_W = DATA_W + HEAD_W;
    localparam int BUF_W = 2 * BLK_W - 2;
    localparam int EXT_W = BUF_W + DATA_W;
    localparam int CNT_W = $clog2(EXT_W);

    localparam logic [CNT_W-1:0] BLK_LEN  = CNT_W'(BLK_W);
    localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(DATA_W);
    // A slip keeps a whole word in the buffer, so it waits until that word still fits.
    localparam logic [CNT_W-1:0] SLIP_MAX = CNT_W'(BUF_W - DATA_W);

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_d;
    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] fill_d;
    logic [CNT_W-1:0] total;
    logic [EXT_W-1:0] merged;
    logic             emit;

    always_comb begin
        merged   = {{DATA_W{1'b0}}, buf_q} | ({{BUF_W{1'b0}}, data_i} << fill_q);
        total    = fill_q + WORD_LEN;
        slip_ack = slip_i && (fill_q <= SLIP_MAX);
        emit     = 1'b0;
        buf_d    = BUF_W'(merged);
        fill_d   = total;
        if (slip_ack) begin
            buf_d  = BUF_W'(merged >> 1);
            fill_d = total - CNT_W'(1);
        end else if (total >= BLK_LEN) begin
            emit   = 1'b1;
            buf_d  = BUF_W'(merged >> BLK_W);
            fill_d = total - BLK_LEN;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            buf_q   <= '0;
            fill_q  <= '0;
            valid_o <= 1'b0;
            block_o <= '0;
            slip_o  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            valid_o <= emit;
            slip_o  <= slip_ack;
            if (emit) begin
                block_o <= merged[BLK_W-1:0];
            end
        end
    end

endmodule

// File: rtl/block_sync_rx.sv
// Per-lane block synchroniser: gearbox plus sync-header lock FSM that slips until headers align.
module block_sync_rx #(
    parameter int DATA_W         = 64,
    parameter int HEAD_W         = pcs_pkg::HEAD_W,
    parameter int SH_CNT_MAX     = pcs_pkg::SH_CNT_MAX_40G,
    parameter int SH_INVALID_MAX = pcs_pkg::SH_INVALID_MAX_40G
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o,
    output logic              lock_o,
    output logic              slip_o
);

    import pcs_pkg::*;

    localparam int BLK_W = DATA_W + HEAD_W;
    localparam int CNT_W = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W = $clog2(SH_INVALID_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SH_CNT_MAX);
    localparam logic [INV_W-1:0] INV_LAST = INV_W'(SH_INVALID_MAX);

    logic [BLK_W-1:0] block;
    logic             gb_valid;
    logic             slip_ack;
    logic             head_ok;
    logic             request;

    lock_state_t      state_q;
    lock_state_t      state_d;
    logic [CNT_W-1:0] sh_cnt_q;
    logic [CNT_W-1:0] sh_cnt_d;
    logic [CNT_W-1:0] sh_cnt_inc;
    logic [INV_W-1:0] inv_q;
    logic [INV_W-1:0] inv_d;
    logic [INV_W-1:0] inv_inc;
    logic             pending_q;
    logic             pending_d;

    gearbox_rx #(
        .DATA_W (DATA_W),
        .HEAD_W (HEAD_W)
    ) u_gearbox (
        .clk      (clk),
        .nreset   (nreset),
        .data_i   (data_i),
        .slip_i   (pending_q),
        .slip_ack (slip_ack),
        .valid_o  (gb_valid),
        .block_o  (block),
        .slip_o   (slip_o)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= UNLOCKED;
            sh_cnt_q  <= '0;
            inv_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_cnt_q  <= sh_cnt_d;
            inv_q     <= inv_d;
            pending_q <= pending_d;
        end
    end

    // Blocks arriving while a slip is outstanding straddle the old alignment and are not judged.
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_d      = inv_q;
        request    = 1'b0;
        head_ok    = sync_valid(block[HEAD_W-1:0]);
        sh_cnt_inc = sh_cnt_q + CNT_W'(1);
        inv_inc    = inv_q + INV_W'(1);
        if (gb_valid && !pending_q) begin
            case (state_q)
                UNLOCKED: begin
                    if (!head_ok) begin
                        request  = 1'b1;
                        sh_cnt_d = '0;
                    end else if (sh_cnt_inc == CNT_LAST) begin
                        state_d  = LOCKED;
                        sh_cnt_d = '0;
                        inv_d    = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_inc;
                    end
                end
                LOCKED: begin
                    if (!head_ok && (inv_inc == INV_LAST)) begin
                        state_d  = UNLOCKED;
                        request  = 1'b1;
                        sh_cnt_d = '0;
                        inv_d    = '0;
                    end else if (sh_cnt_inc == CNT_LAST) begin
                        sh_cnt_d = '0;
                        inv_d    = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_inc;
                        if (!head_ok) begin
                            inv_d = inv_inc;
                        end
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
        pending_d = (pending_q && !slip_ack) || request;
    end

    assign valid_o = gb_valid;
    assign head_o  = block[HEAD_W-1:0];
    assign data_o  = block[BLK_W-1:HEAD_W];
    assign lock_o  = (state_q == LOCKED);

endmodule

// File: tb/tb_block_sync_rx.sv
// Randomised bench for block_sync_rx: a bit-serial transmitter feeds the DUT and a bit-queue reference predicts every cycle.
module tb_block_sync_rx;

    import pcs_pkg::*;

    localparam int CNT_MAX = 1024;
    localparam int INV_MAX = 65;
    localparam int NBLK    = 8192;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [63:0] data_i = '0;
    logic        valid_o;
    logic [1:0]  head_o;
    logic [63:0] data_o;
    logic        lock_o;
    logic        slip_o;

    always #5 clk = ~clk;

    block_sync_rx #(
        .DATA_W         (64),
        .HEAD_W         (2),
        .SH_CNT_MAX     (CNT_MAX),
        .SH_INVALID_MAX (INV_MAX)
    ) dut (
        .clk     (clk),
        .nreset  (nreset),
        .data_i  (data_i),
        .valid_o (valid_o),
        .head_o  (head_o),
        .data_o  (data_o),
        .lock_o  (lock_o),
        .slip_o  (slip_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter: serialises 66-bit blocks, header bits first, payload bit 0 next.
    bit tx_q[$];
    int tx_blk;
    int payload_mode;
    bit corrupt[NBLK];

    function automatic void txPushBlock();
        logic [1:0]  h;
        logic [63:0] p;
        if (tx_blk < NBLK && corrupt[tx_blk])
            h = ($urandom_range(1, 0) == 1) ? 2'b11 : 2'b00;
        else if (payload_mode == 0)
            h = SYNC_DATA;
        else
            h = ($urandom_range(1, 0) == 1) ? SYNC_DATA : SYNC_CTRL;
        p = (payload_mode == 0) ? 64'(tx_blk) : {$urandom(), $urandom()};
        tx_q.push_back(h[0]);
        tx_q.push_back(h[1]);
        for (int i = 0; i < 64; i++) tx_q.push_back(p[i]);
        tx_blk++;
    endfunction

    function automatic logic [63:0] nextWord();
        logic [63:0] w;
        while (tx_q.size() < 64) txPushBlock();
        for (int i = 0; i < 64; i++) w[i] = tx_q.pop_front();
        return w;
    endfunction

    function automatic void markCorrupt(input int lo, input int hi, input int count);
        int placed = 0;
        while (placed < count) begin
            int k;
            k = $urandom_range(hi, lo);
            if (!corrupt[k]) begin
                corrupt[k] = 1'b1;
                placed++;
            end
        end
    endfunction

    // Reference: received bits sit in a queue; blocks are 66-bit pops, a slip drops the oldest bit.
    bit          mq[$];
    bit          m_valid, m_slip, m_lock, m_pending;
    logic [65:0] m_block;
    int          m_sh, m_inv;

    function automatic void modelReset();
        mq.delete();
        m_valid = 0; m_slip = 0; m_lock = 0; m_pending = 0;
        m_block = '0; m_sh = 0; m_inv = 0;
    endfunction

    function automatic void modelStep(input logic [63:0] w);
        bit ack, req, hv;
        ack = m_pending && (mq.size() <= 66);
        req = 0;
        if (m_valid && !m_pending) begin
            hv = (m_block[1:0] == 2'b01) || (m_block[1:0] == 2'b10);
            if (!m_lock) begin
                if (!hv) begin
                    req = 1; m_sh = 0;
                end else begin
                    m_sh++;
                    if (m_sh == CNT_MAX) begin m_lock = 1; m_sh = 0; m_inv = 0; end
                end
            end else begin
                m_sh++;
                if (!hv) m_inv++;
                if (m_inv == INV_MAX) begin m_lock = 0; req = 1; m_sh = 0; m_inv = 0; end
                else if (m_sh == CNT_MAX) begin m_sh = 0; m_inv = 0; end
            end
        end
        m_pending = (m_pending && !ack) || req;
        for (int i = 0; i < 64; i++) mq.push_back(w[i]);
        m_slip  = ack;
        m_valid = 0;
        if (ack) begin
            mq.delete(0);
        end else if (mq.size() >= 66) begin
            for (int i = 0; i < 66; i++) m_block[i] = mq.pop_front();
            m_valid = 1;
        end
    endfunction

    int          cyc, nvalid, first_valid, vwin, slip_count, blocks_at_lock;
    bit          lock_seen;
    logic [63:0] first_data;

    task automatic checkCycle();
        checkOutput("valid", valid_o, m_valid);
        checkOutput("lock", lock_o, m_lock);
        checkOutput("slip", slip_o, m_slip);
        if (m_valid) begin
            checkOutput("head", head_o, m_block[1:0]);
            checkOutput("data", data_o, m_block[65:2]);
        end
        if (lock_o === 1'b1 && !lock_seen) begin
            lock_seen = 1;
            blocks_at_lock = nvalid;
        end
        if (valid_o === 1'b1) begin
            if (first_valid < 0) begin
                first_valid = cyc;
                first_data = data_o;
            end
            nvalid++;
            if (cyc >= 2 && cyc <= 34) vwin++;
        end
        if (slip_o === 1'b1) slip_count++;
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            logic [63:0] w;
            w = nextWord();
            data_i = w;
            @(posedge clk);
            modelStep(w);
            cyc++;
            @(negedge clk);
            checkCycle();
        end
    endtask

    task automatic doReset();
        nreset = 1'b0;
        modelReset();
        tx_q.delete();
        tx_blk = 0;
        foreach (corrupt[k]) corrupt[k] = 1'b0;
        cyc = 0; nvalid = 0; first_valid = -1; vwin = 0; slip_count = 0;
        blocks_at_lock = -1; lock_seen = 0; first_data = '1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", {valid_o, lock_o, slip_o, head_o, data_o}, '0);
        nreset = 1'b1;
    endtask

    task automatic runUntilLock(input int budget, input string tag);
        int n = 0;
        while (lock_o !== 1'b1 && n < budget) begin
            applyStimulus(1);
            n++;
        end
        checkOutput(tag, lock_o, 1'b1);
    endtask

    task automatic checkStartup();
        applyStimulus(34);
        checkOutput("first_valid_cycle", first_valid, 2);
        checkOutput("first_payload", first_data, 64'd0);
        checkOutput("valids_per_33", vwin, 32);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Aligned counter stream: lock, tolerate 64 invalids, lose lock on 65, relock, reset mid-run.
        payload_mode = 0;
        doReset();
        markCorrupt(1024, 2047, 64);
        markCorrupt(2048, 3071, 65);
        checkStartup();
        runUntilLock(1200, "lock_aligned");
        checkOutput("blocks_before_lock", blocks_at_lock, CNT_MAX);
        applyStimulus(1100);
        checkOutput("locked_after_64_invalid", lock_o, 1'b1);
        checkOutput("no_slip_64_invalid", slip_count, 0);
        payload_mode = 1;
        applyStimulus(1050);
        checkOutput("unlocked_after_65_invalid", lock_o, 1'b0);
        checkOutput("slip_after_loss", slip_count > 0, 1'b1);
        runUntilLock(8000, "relock_after_loss");
        applyStimulus(5);
        #2;
        nreset = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {valid_o, lock_o, slip_o, head_o, data_o}, '0);

        // Same stream after reset; 65th invalid lands on the final block of a window.
        payload_mode = 0;
        doReset();
        markCorrupt(1024, 2046, 64);
        corrupt[2047] = 1'b1;
        checkStartup();
        runUntilLock(1200, "lock_after_reset");
        checkOutput("blocks_before_relock", blocks_at_lock, CNT_MAX);
        applyStimulus(1100);
        checkOutput("loss_wins_at_window_end", lock_o, 1'b0);
        checkOutput("slip_at_window_end", slip_count > 0, 1'b1);

        // Random payload pre-shifted by 17 bits: must slip into alignment and lock.
        payload_mode = 1;
        doReset();
        for (int i = 0; i < 17; i++) tx_q.push_back(1'($urandom_range(1, 0)));
        runUntilLock(6000, "lock_shifted");
        checkOutput("slips_on_shifted", slip_count >= 17, 1'b1);
        applyStimulus(200);
        checkOutput("locked_shifted_end", lock_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_sync_rx.md
Name: block_sync_rx

Overview:
- Per-lane receive front end of the 40G PCS; mirror of the transmit encoder/scrambler/gearbox path.
- Takes a raw 64-bit word from the PMA every cycle and rebuilds 66-bit blocks through a 64:66 gearbox with bit-slip.
- Runs the sync-header block-lock state machine, driving slips until headers align.
- Emits aligned header/payload pairs plus lock status to the downstream descrambler and alignment-marker lock. One instance per lane.

Parameters:
- DATA_W, 64, payload bits per block and PMA word width.
- HEAD_W, 2, sync header width.
- SH_CNT_MAX, 1024, blocks per lock test window (set 64 for 10G).
- SH_INVALID_MAX, 65, invalid headers per window that break lock (set 16 for 10G).

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- data_i  in  DATA_W  PMA word; bit 0 is the earliest received bit
- valid_o  out  1  a block is present on head_o/data_o
- head_o  out  HEAD_W  sync header, stream bits [1:0] of the block
- data_o  out  DATA_W  still-scrambled payload, stream bits [65:2]
- lock_o  out  1  block lock achieved
- slip_o  out  1  one-cycle pulse; one bit discarded this cycle (debug)

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low.
  - Reset values: valid_o=0, head_o=0, data_o=0, lock_o=0, slip_o=0, fill=0, all counters 0, FSM=UNLOCKED.
- Gearbox:
  - 130-bit buffer with a fill count (0..129).
  - Each cycle data_i is appended at bit position fill.
  - If a slip is pending, bit 0 of the buffer is discarded first (fill-1). No block is emitted in that cycle, and slip_o pulses.
  - Otherwise, if fill+64 >= 66, bits [65:0] are emitted as a block, the buffer shifts down by 66, and fill = fill+64-66. Else fill = fill+64.
  - Outputs are registered: a block appears one cycle after the edge that sampled its final bit.
  - Steady state: first valid_o on the 2nd sampled word after reset, then exactly 32 valid cycles per 33.
- Header test: a block header is valid iff head = 2'b01 or 2'b10.
- FSM UNLOCKED:
  - Each valid header increments sh_cnt.
  - An invalid header requests a slip and clears sh_cnt.
  - When sh_cnt reaches SH_CNT_MAX, go to LOCKED: lock_o=1 and both counters clear.
  - Every block emitted while UNLOCKED is still presented on valid_o.
- FSM LOCKED:
  - Each block increments sh_cnt; each invalid header also increments sh_invalid_cnt.
  - If sh_invalid_cnt reaches SH_INVALID_MAX, go to UNLOCKED: lock_o drops on the next cycle, a slip is requested, and counters clear.
  - Else when sh_cnt reaches SH_CNT_MAX, both counters clear and the state stays LOCKED.
- Simultaneous events: if the last block of a window is also the SH_INVALID_MAX-th invalid header, loss of lock wins.
- Slip pending:
  - At most one slip is outstanding; the header test is suspended until the slip has executed.
  - The next emitted block is tested normally.
- Counter widths:
  - sh_cnt is $clog2(SH_CNT_MAX+1) bits; sh_invalid_cnt is $clog2(SH_INVALID_MAX+1) bits.
  - Neither counter wraps: both always clear at their limits.
- Reset mid-operation: reset asserted at any time returns everything to the reset values immediately; partial buffer contents are discarded.

Decomposition:
- Shared package pcs_pkg:
  - HEAD_W, sync header constants SYNC_DATA=2'b01 and SYNC_CTRL=2'b10.
  - Lock FSM state enum {UNLOCKED, LOCKED}.
  - The 40G and 10G lock limits.
- Sub-module gearbox_rx:
  - Owns the buffer, fill count and slip execution, with ports slip_i, valid_o, block_o.
  - block_sync_rx wraps it with the lock FSM and counters.

Test Plan:
1. Aligned stream, header 01, payload = incrementing counter -> first valid_o on the 2nd word after reset, 32 valids per 33 cycles, data_o counts 0,1,2..., lock_o=1 on the cycle after the SH_CNT_MAX-th block.
2. Same stream pre-shifted by 17 bits, SH_CNT_MAX=64/SH_INVALID_MAX=16, payload from a PRBS31 -> slip_o pulses, lock_o rises within 50k cycles, all subsequent blocks bit-exact to transmitted blocks.
3. Locked, inject 64 invalid headers (00/11) in one 1024-block window -> lock_o stays 1, no slip_o; the next window starts clean.
4. Locked, inject 65 invalid headers in one window -> lock_o=0 the cycle after the 65th, slip_o pulses once, relock follows.
5. The 65th invalid header placed on the last block of a window -> loss of lock takes precedence; lock_o=0.
6. nreset asserted mid-block while locked -> all outputs 0 asynchronously; after release, behaviour identical to scenario 1.
